hdmi_timing_gen: RTL

- Pixel-clock video timing and test-pattern source. Sits directly upstream of the HDMI TMDS control block and drives its rgb_red/green/blue, hsync, vsync and de inputs.
- Generates parameterised horizontal and vertical sync, porch and active regions, with active-region pixel coordinates.
- Fills the active region from a selectable built-in pattern. The pattern is latched at frame boundaries so frames are never torn.

---
 rtl/hdmi_timing_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/hdmi_timing_gen.sv
// Free-running video timing generator with registered sync/de/coordinates and a built-in
// test-pattern source; the pattern select is latched once per frame so frames never tear.
module hdmi_timing_gen #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk_1x,
  input  logic        sys_rst_n,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  rgb_red,
  output logic [7:0]  rgb_green,
  output logic [7:0]  rgb_blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA_S    = H_SYNC + H_BACK;
  localparam int HA_E    = HA_S + H_ACTIVE;
  localparam int VA_S    = V_SYNC + V_BACK;
  localparam int VA_E    = VA_S + V_ACTIVE;
  localparam int BAR_W   = H_ACTIVE / 8;

  logic [11:0] h_q, h_d, v_q, v_d;
  logic [1:0]  mode_q, mode_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        de_q, de_d, fs_q, fs_d;
  logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  logic        h_act, v_act, at_origin;
  logic [11:0] px, py;
  logic [2:0]  bar;
  logic [23:0] pat;

  always_comb begin
    at_origin = (h_q == 12'd0) && (v_q == 12'd0);
    h_d       = h_q + 12'd1;
    v_d       = v_q;
    if (int'(h_q) == H_TOTAL - 1) begin
      h_d = 12'd0;
      v_d = (int'(v_q) == V_TOTAL - 1) ? 12'd0 : v_q + 12'd1;
    end
    mode_d = at_origin ? mode : mode_q;
  end

  always_comb begin
    h_act = (int'(h_q) >= HA_S) && (int'(h_q) < HA_E);
    v_act = (int'(v_q) >= VA_S) && (int'(v_q) < VA_E);
    px    = h_q - 12'(HA_S);
    py    = v_q - 12'(VA_S);
    bar   = 3'(int'(px) / BAR_W);
    // Bar order white..black maps to R=~bar[1], G=~bar[2], B=~bar[0].
    case (mode_q)
      2'd0:    pat = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      2'd1:    pat = {3{px[7:0]}};
      2'd2:    pat = solid_rgb;
      default: pat = {24{~(px[5] ^ py[5])}};
    endcase
    de_d    = h_act && v_act;
    rgb_d   = de_d ? pat : 24'd0;
    pix_x_d = de_d ? px : 12'd0;
    pix_y_d = de_d ? py : 12'd0;
    hsync_d = (int'(h_q) < H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (int'(v_q) < V_SYNC) ? SYNC_POL : ~SYNC_POL;
    fs_d    = at_origin;
  end

  always_ff @(posedge clk_1x or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_q     <= 12'd0;
      v_q     <= 12'd0;
      mode_q  <= 2'd0;
      rgb_q   <= 24'd0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      pix_x_q <= 12'd0;
      pix_y_q <= 12'd0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      fs_q    <= fs_d;
    end
  end

  assign rgb_red     = rgb_q[23:16];
  assign rgb_green   = rgb_q[15:8];
  assign rgb_blue    = rgb_q[7:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;

endmodule
